store_unit: RTL and testbench

// Memory-side store path of the core: the write counterpart of the load

---
 rtl/store_unit.sv | 140 ++++++++++++++
 tb/tb_store_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store path: turns an S-type instruction into a word-aligned data-memory write with byte enables.
// One cycle from accept to request; request held until ack or timeout; ready_o low while a request is outstanding.
module store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    output logic        done_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic {IDLE, REQ} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic          r_done;
    logic          r_fault;
    logic [1:0]    r_fault_cause;

    logic [2:0]  w_funct3;
    logic [1:0]  w_lane;
    logic        w_accept;
    logic        w_illegal;
    logic        w_misal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_unused_instr;

    assign w_funct3       = instr_i[14:12];
    assign w_lane         = addr_i[1:0];
    assign w_unused_instr = ^{instr_i[31:15], instr_i[11:7]};
    assign ready_o        = (r_state == IDLE) && !rst;
    assign w_accept       = valid_i && ready_o && (instr_i[6:0] == OPC_STORE);

    always_comb begin
        w_be      = 4'b0000;
        w_wdata   = 32'h0;
        w_misal   = 1'b0;
        w_illegal = 1'b0;
        case (w_funct3)
            3'b000: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{data_i[7:0]}};
            end
            3'b001: begin
                w_misal = w_lane[0];
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data_i[15:0]}};
            end
            3'b010: begin
                w_misal = (w_lane != 2'b00);
                w_be    = 4'b1111;
                w_wdata = data_i;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_mem_be      <= 4'b0000;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= 2'b00;
        end else begin
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Illegal encoding takes priority: its lane fields are meaningless.
                        if (w_illegal) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= 2'b11;
                        end else if (w_misal) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= 2'b01;
                        end else begin
                            r_mem_addr  <= {addr_i[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_be    <= w_be;
                            r_mem_req   <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked before the timeout so a last-cycle ack still succeeds.
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_mem_req     <= 1'b0;
                        r_fault       <= 1'b1;
                        r_fault_cause <= 2'b10;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req_o     = r_mem_req;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;
    assign mem_be_o      = r_mem_be;
    assign done_o        = r_done;
    assign fault_o       = r_fault;
    assign fault_cause_o = r_fault_cause;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected completions are queued at drive time and
// matched against done_o/fault_o and the request fields seen on the memory interface.
module tb_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic        ready_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i = 1'b0;
    logic        done_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;

    store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i),
        .addr_i(addr_i), .data_i(data_i), .ready_o(ready_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i), .done_o(done_o),
        .fault_o(fault_o), .fault_cause_o(fault_cause_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          flt;
        logic [1:0]  cause;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   req_cnt = 0;
    logic req_prev = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.flt = 1'b0; e.cause = 2'b00; e.addr = a & 32'hFFFF_FFFC; e.be = 4'b0; e.wdata = 32'h0;
        if (f3 == 3'd0) begin
            for (int i = 0; i < 4; i++) begin
                e.wdata[i*8 +: 8] = d[7:0];
                e.be[i] = (a[1:0] == 2'(i));
            end
        end else if (f3 == 3'd1) begin
            if (a[0]) begin e.flt = 1'b1; e.cause = 2'b01; end
            e.wdata = {d[15:0], d[15:0]};
            e.be = (a[1]) ? 4'b1100 : 4'b0011;
        end else if (f3 == 3'd2) begin
            if (a[1:0] != 2'b00) begin e.flt = 1'b1; e.cause = 2'b01; end
            e.wdata = d; e.be = 4'b1111;
        end else begin
            e.flt = 1'b1; e.cause = 2'b11;
        end
        return e;
    endfunction

    function automatic logic [31:0] st_instr(input logic [2:0] f3);
        return {17'h0, f3, 5'h0, 7'b0100011};
    endfunction

    // Monitor: request-field capture/hold, and completion matching against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mem_req_o) begin
            req_cnt++;
            if (!req_prev) begin
                cap_addr = mem_addr_o; cap_wdata = mem_wdata_o; cap_be = mem_be_o;
            end else begin
                check("hold_addr", mem_addr_o, cap_addr);
                check("hold_be", {28'h0, mem_be_o}, {28'h0, cap_be});
            end
        end
        req_prev = mem_req_o;
        if (done_o || fault_o) begin
            check("done_fault_excl", {31'h0, done_o & fault_o}, 32'h0);
            if (sb.size() == 0) begin
                check("unexpected_completion", {31'h0, done_o | fault_o}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("kind_fault", {31'h0, fault_o}, {31'h0, e.flt});
                if (fault_o) begin
                    check("fault_cause", {30'h0, fault_cause_o}, {30'h0, e.cause});
                end else begin
                    check("done_req_low", {31'h0, mem_req_o}, 32'h0);
                    check("mem_addr", cap_addr, e.addr);
                    check("mem_wdata", cap_wdata, e.wdata);
                    check("mem_be", {28'h0, cap_be}, {28'h0, e.be});
                end
            end
        end
    end

    task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        valid_i = 1'b1; instr_i = st_instr(f3); addr_i = a; data_i = d;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // ack_after < 0: never ack. Otherwise ack in the (ack_after+1)-th request cycle.
    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input int ack_after);
        exp_t e;
        int base, want_req;
        e = model(f3, a, d);
        if (e.flt) want_req = 0;
        else if (ack_after < 0 || ack_after >= TMO) begin
            e.flt = 1'b1; e.cause = 2'b10; want_req = TMO;
        end else want_req = ack_after + 1;
        sb.push_back(e);
        base = req_cnt;
        present(f3, a, d);
        if (!e.flt || e.cause == 2'b10) begin
            for (int k = 0; k < TMO; k++) begin
                mem_ack_i = (k == ack_after);
                @(posedge clk); #1;
                if (k == ack_after) break;
            end
            mem_ack_i = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("req_cycles", 32'(req_cnt - base), 32'(want_req));
        check("sb_drained", 32'(sb.size()), 32'h0);
        while (sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        int base;
        exp_t e1, e2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_ready", {31'h0, ready_o}, 32'h0);
        check("rst_req", {31'h0, mem_req_o}, 32'h0);
        check("rst_done_fault", {30'h0, done_o, fault_o}, 32'h0);
        check("rst_fields", mem_addr_o ^ mem_wdata_o ^ {28'h0, mem_be_o} ^ {30'h0, fault_cause_o}, 32'h0);
        rst = 1'b0; #1;
        check("ready_after_rst", {31'h0, ready_o}, 32'h1);

        do_store(3'b000, 32'h0000_1003, 32'h0000_00AB, 0);
        do_store(3'b001, 32'h0000_2002, 32'h0000_1234, 2);
        do_store(3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 1);
        do_store(3'b010, 32'h0000_2001, 32'h1111_2222, 0);
        do_store(3'b001, 32'h0000_2003, 32'h3333_4444, 0);
        do_store(3'b011, 32'h0000_4000, 32'h5555_6666, 0);
        do_store(3'b110, 32'h0000_4004, 32'h5555_6666, 0);
        do_store(3'b010, 32'h0000_5000, 32'hCAFE_F00D, -1);
        do_store(3'b000, 32'h0000_5001, 32'h0000_0077, TMO - 1);

        // Non-store opcode must be ignored entirely.
        base = req_cnt;
        valid_i = 1'b1; instr_i = 32'h0000_2033; addr_i = 32'h8; data_i = 32'h1;
        @(posedge clk); #1; valid_i = 1'b0;
        @(posedge clk); #1;
        check("nonstore_req", 32'(req_cnt - base), 32'h0);
        check("nonstore_ready", {31'h0, ready_o}, 32'h1);

        // Back-to-back SB stores; valid_i held through REQ with the second store.
        e1 = model(3'b000, 32'h0000_6001, 32'h0000_00C3);
        e2 = model(3'b000, 32'h0000_7002, 32'h0000_005A);
        sb.push_back(e1); sb.push_back(e2);
        base = req_cnt;
        valid_i = 1'b1; instr_i = st_instr(3'b000); addr_i = 32'h0000_6001; data_i = 32'h0000_00C3;
        @(posedge clk); #1;
        addr_i = 32'h0000_7002; data_i = 32'h0000_005A; mem_ack_i = 1'b1;
        check("b2b_ready_in_req", {31'h0, ready_o}, 32'h0);
        @(posedge clk); #1;
        check("b2b_done_pulse", {31'h0, done_o}, 32'h1);
        check("b2b_ready_on_done", {31'h0, ready_o}, 32'h1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("b2b_second_req", {31'h0, mem_req_o}, 32'h1);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        @(posedge clk); #1;
        check("b2b_req_cycles", 32'(req_cnt - base), 32'h2);
        check("b2b_sb_drained", 32'(sb.size()), 32'h0);
        while (sb.size() != 0) void'(sb.pop_front());

        for (int i = 0; i < 12; i++) begin
            do_store(3'($urandom_range(0, 3)), $urandom & 32'h0000_FFFF, $urandom,
                     int'($urandom_range(0, 5)));
        end

        // Reset while a request is outstanding drops the store silently.
        present(3'b010, 32'h0000_9000, 32'h1234_5678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_req_high", {31'h0, mem_req_o}, 32'h1);
        rst = 1'b1; #1;
        check("mid_rst_ready", {31'h0, ready_o}, 32'h0);
        @(posedge clk); #1;
        check("mid_rst_req", {31'h0, mem_req_o}, 32'h0);
        check("mid_rst_done_fault", {30'h0, done_o, fault_o}, 32'h0);
        rst = 1'b0; #1;
        check("mid_rst_ready_after", {31'h0, ready_o}, 32'h1);
        @(posedge clk); #1;
        do_store(3'b000, 32'h0000_A002, 32'h0000_0099, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
